// File: rtl/conv_result_reader_if.sv
// Result stream from conv_result_reader: one 8-bit beat per transfer.
// The master side drives the beat and the slave side drives m_ready.
interface conv_result_reader_if;
    logic [7:0] m_data;
    logic [1:0] m_idx;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        output m_data,
        output m_idx,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_idx,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/conv_result_reader.sv
// Waits LATENCY cycles after a start, snapshots the 2x2 convolution result,
// then streams the four bytes out over a valid/ready port.
module conv_result_reader #(
    parameter int unsigned LATENCY = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                        clk_in,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  o00,
    input  logic [7:0]                  o01,
    input  logic [7:0]                  o10,
    input  logic [7:0]                  o11,
    conv_result_reader_if.master        m,
    output logic                        busy,
    output logic                        overrun
);

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_t;

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic [3:0][7:0]      snap_q, snap_d;
    logic                 overrun_q, overrun_d;
    logic                 sending;
    logic                 xfer;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs depend only on registered state, never on m_ready.
    assign sending = (state_q == StSend);
    assign xfer    = sending && m.m_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    snap_d  = {o11, o10, o01, o00};
                    idx_d   = 2'd0;
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSend: begin
                if (xfer) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A start that lands while busy is dropped but remembered until reset.
        if (start && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        m.m_valid = sending;
        m.m_data  = sending ? snap_q[idx_q] : 8'h00;
        m.m_idx   = idx_q;
        m.m_last  = sending && (idx_q == 2'd3);
        busy      = (state_q != StIdle);
        overrun   = overrun_q;
    end

endmodule

// File: tb/tb_conv_result_reader.sv
// Scoreboard bench for conv_result_reader: a LATENCY=16 instance for frame,
// backpressure, isolation, overrun and reset cases, plus a LATENCY=1 instance.
module tb_conv_result_reader;

    localparam int unsigned LatA = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [7:0] a00, a01, a10, a11;
    logic       busy_a, ovr_a, busy_b, ovr_b;

    conv_result_reader_if ma();
    conv_result_reader_if mb();

    conv_result_reader #(.LATENCY(LatA), .CNT_W(8)) dut_a (
        .clk_in  (clk),
        .rst     (rst),
        .start   (start_a),
        .o00     (a00),
        .o01     (a01),
        .o10     (a10),
        .o11     (a11),
        .m       (ma.master),
        .busy    (busy_a),
        .overrun (ovr_a)
    );

    conv_result_reader #(.LATENCY(1), .CNT_W(8)) dut_b (
        .clk_in  (clk),
        .rst     (rst),
        .start   (start_b),
        .o00     (8'h5A),
        .o01     (8'h6B),
        .o10     (8'h7C),
        .o11     (8'h8D),
        .m       (mb.master),
        .busy    (busy_b),
        .overrun (ovr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    beat_t b_a;
    int    xfer_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        exp_q.push_back('{idx: 2'd0, data: a00, last: 1'b0});
        exp_q.push_back('{idx: 2'd1, data: a01, last: 1'b0});
        exp_q.push_back('{idx: 2'd2, data: a10, last: 1'b0});
        exp_q.push_back('{idx: 2'd3, data: a11, last: 1'b1});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_valid(input int exp_lat);
        int n = 0;
        while (!ma.m_valid && n < 300) begin
            tick();
            n++;
        end
        check("latency", n, exp_lat);
    endtask

    task automatic drain();
        int n = 0;
        while (busy_a && n < 300) begin
            tick();
            n++;
        end
        check("drain_busy", busy_a, 1'b0);
        check("drain_valid", ma.m_valid, 1'b0);
    endtask

    // Stream A monitor: scoreboard on transfers, stability while stalled.
    logic       pv, pr;
    logic [7:0] pd;
    logic [1:0] pi;
    always @(negedge clk) begin
        if (!rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", ma.m_valid, 1'b1);
                check("hold_data", ma.m_data, pd);
                check("hold_idx", ma.m_idx, pi);
            end
            if (ma.m_valid && ma.m_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    b_a = exp_q.pop_front();
                    check("beat_idx", ma.m_idx, b_a.idx);
                    check("beat_data", ma.m_data, b_a.data);
                    check("beat_last", ma.m_last, b_a.last);
                end
            end
            pv = ma.m_valid;
            pr = ma.m_ready;
            pd = ma.m_data;
            pi = ma.m_idx;
        end
    end

    // Stream B monitor: fixed data table, records when each frame begins.
    int         cyc = 0;
    int         exp_ib = 0;
    int         frame_t[$];
    logic [7:0] tbl_b [4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst && mb.m_valid) begin
            check("b_idx", mb.m_idx, exp_ib);
            check("b_data", mb.m_data, tbl_b[exp_ib]);
            check("b_last", mb.m_last, exp_ib == 3);
            if (exp_ib == 0) frame_t.push_back(cyc);
            exp_ib = (exp_ib + 1) % 4;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int nb;
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        {a00, a01, a10, a11} = '0;
        ma.m_ready = 1'b1;
        mb.m_ready = 1'b1;
        #2;
        check("rst_valid", ma.m_valid, 1'b0);
        check("rst_data", ma.m_data, 8'h00);
        check("rst_idx", ma.m_idx, 2'd0);
        check("rst_last", ma.m_last, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_overrun", ovr_a, 1'b0);
        #20;
        rst = 1'b1;
        tick();

        // Basic frame
        {a00, a01, a10, a11} = {8'h11, 8'h22, 8'h33, 8'h44};
        launch();
        check("basic_busy", busy_a, 1'b1);
        check("basic_valid_early", ma.m_valid, 1'b0);
        wait_valid(LatA);
        repeat (4) tick();
        check("basic_busy_end", busy_a, 1'b0);
        check("basic_overrun", ovr_a, 1'b0);
        check("basic_empty", exp_q.size(), 0);

        // Backpressure
        ma.m_ready = 1'b0;
        xfer_cnt   = 0;
        launch();
        wait_valid(LatA);
        repeat (3) tick();
        r  = 1;
        nb = 0;
        while (busy_a && nb < 40) begin
            ma.m_ready = r[0];
            tick();
            r = ~r;
            nb++;
        end
        ma.m_ready = 1'b1;
        check("bp_busy_end", busy_a, 1'b0);
        check("bp_xfers", xfer_cnt, 4);

        // Snapshot isolation
        launch();
        wait_valid(LatA);
        {a00, a01, a10, a11} = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        drain();
        launch();
        wait_valid(LatA);
        drain();

        // Overrun in WAIT and SEND
        {a00, a01, a10, a11} = {8'h01, 8'h02, 8'h03, 8'h04};
        launch();
        repeat (4) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("ovr_wait", ovr_a, 1'b1);
        check("ovr_busy", busy_a, 1'b1);
        repeat (10) tick();
        check("ovr_valid_early", ma.m_valid, 1'b0);
        tick();
        check("ovr_valid_on_time", ma.m_valid, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("ovr_send", ovr_a, 1'b1);
        check("ovr_no_restart", ma.m_idx, 2'd1);
        drain();
        check("ovr_sticky", ovr_a, 1'b1);
        {a00, a01, a10, a11} = {8'h9E, 8'h8F, 8'h70, 8'h61};
        launch();
        wait_valid(LatA);
        drain();
        check("ovr_sticky2", ovr_a, 1'b1);

        // Reset mid-SEND
        {a00, a01, a10, a11} = {8'h21, 8'h43, 8'h65, 8'h87};
        launch();
        wait_valid(LatA);
        tick();
        tick();
        check("mid_idx", ma.m_idx, 2'd2);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", ma.m_valid, 1'b0);
        check("mid_rst_data", ma.m_data, 8'h00);
        check("mid_rst_idx", ma.m_idx, 2'd0);
        check("mid_rst_last", ma.m_last, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_overrun", ovr_a, 1'b0);
        exp_q.delete();
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy_a, 1'b0);
        {a00, a01, a10, a11} = {8'hF0, 8'hE1, 8'hD2, 8'hC3};
        launch();
        wait_valid(LatA);
        drain();
        check("final_empty", exp_q.size(), 0);

        // Back-to-back, LATENCY=1, start held
        start_b = 1'b1;
        repeat (40) tick();
        start_b = 1'b0;
        nb = 0;
        while (busy_b && nb < 20) begin
            tick();
            nb++;
        end
        check("b_idle", busy_b, 1'b0);
        check("b_frames", frame_t.size() >= 5, 1'b1);
        for (int i = 1; i < frame_t.size(); i++) begin
            check("b_period", frame_t[i] - frame_t[i-1], 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_result_reader.md
Name: conv_result_reader

Overview:
- Read-side companion to the 3x3 systolic convolution core.
- Launches on a start pulse and waits a fixed number of cycles for the core's 2x2 result (o00, o01, o10, o11) to settle.
- Snapshots the four 8-bit results, then streams them one per beat over a valid/ready interface to downstream logic (memory writer or UART bridge).
- Frees the core for its next operation as soon as the snapshot is taken.

Parameters:
- LATENCY, 16, clock edges from the start-accept edge to the capture edge; legal range 1..255.
- CNT_W, 8, width of the internal wait counter; must satisfy 2^CNT_W > LATENCY.

Ports:
- clk_in  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-low reset. Assertion (0) clears all state immediately; release is taken on the next rising edge.
- start  input  1  Launch request. Accepted only in IDLE.
- o00  input  8  Core result, row 0 col 0.
- o01  input  8  Core result, row 0 col 1.
- o10  input  8  Core result, row 1 col 0.
- o11  input  8  Core result, row 1 col 1.
- m_data  output  8  Current result beat.
- m_idx  output  2  Beat index: 0=o00, 1=o01, 2=o10, 3=o11.
- m_valid  output  1  Beat valid.
- m_ready  input  1  Downstream accept.
- m_last  output  1  High together with the idx-3 beat.
- busy  output  1  High in WAIT and SEND.
- overrun  output  1  Sticky flag: start seen while busy.

Behaviour:
- Reset: state=IDLE, wait counter=0, beat index=0, snapshot registers=0; outputs m_data=0, m_idx=0, m_valid=0, m_last=0, busy=0, overrun=0.
- States: IDLE, WAIT, SEND.
- IDLE:
  - start=1 at edge E0 -> WAIT, counter loaded with LATENCY-1, busy=1 after E0.
  - start is level-sampled, so start held high relaunches immediately on return to IDLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==0 (edge E0+LATENCY): latch o00..o11 into the snapshot, set beat index=0, go to SEND.
  - m_valid=1 from that edge onward.
  - Result: start-accept to first m_valid = LATENCY cycles.
- SEND:
  - m_data = snapshot[m_idx]; m_last = (m_idx==3); m_valid=1.
  - A beat transfers on an edge with m_valid && m_ready.
  - On transfer with idx<3: idx increments, next beat presented in the following cycle. No bubbles, so one beat per cycle under continuous m_ready=1.
  - On transfer with idx==3: go to IDLE; m_valid=0, busy=0, m_idx=0, m_last=0 after that edge.
  - While m_valid && !m_ready: m_data, m_idx and m_last hold stable. The block never deasserts m_valid without a transfer.
- Snapshot isolation: o00..o11 are sampled only on the capture edge. Input changes during WAIT (before capture) or during SEND have no effect on the transmitted data.
- start while busy: ignored (no restart, counter and beat index undisturbed); overrun set to 1. overrun clears only on reset.
- start and the final beat transfer on the same edge: start is ignored and sets overrun, because the state was SEND on that edge.
- LATENCY=1: capture occurs on the edge after the start-accept edge.
- Reset mid-operation (WAIT or SEND): immediate return to reset values; a partially sent frame is abandoned, not resumed.
- m_ready is don't-care outside SEND.
- No combinational path from m_ready to m_valid or m_data.

Test Plan:
- Basic frame: LATENCY=16, o00..o11 = 0x11/0x22/0x33/0x44 stable, m_ready=1, start pulse at edge 0 -> m_valid rises after edge 16. Beats in cycles 16..19 carry idx 0..3, data 11,22,33,44; m_last only on 0x44. busy falls after edge 20; overrun=0.
- Backpressure: same setup, m_ready=0 in cycles 16-18, then toggled 1,0,1,0,... -> each beat holds its data/idx until accepted. Exactly 4 transfers, in order, no duplicates.
- Snapshot isolation: inputs change to 0xAA..0xDD after edge 16 -> the stream still carries 0x11..0x44. A second frame launched afterwards carries 0xAA..0xDD.
- Overrun: start pulses at edge 5 (WAIT) and edge 17 (SEND) -> overrun=1 after edge 5 and stays high. Frame timing and data are unchanged. A new start in IDLE launches normally; overrun stays 1.
- Reset mid-SEND: assert rst=0 asynchronously after the idx-1 beat -> all outputs go to 0 immediately without a clock edge. After release, IDLE; the next start gives a full frame starting at idx 0.
- Back-to-back with start held high, LATENCY=1, m_ready=1 -> frames repeat every 6 cycles (1 wait + 4 beats + 1 IDLE accept cycle).
